// File: rtl/console_pkg.sv
// console_pkg: shared ASCII codes, sequencer states and byte classification for vga_console.
// Contents: CH_* control/fill codes, state_t, printable().
// Macro VGA_CONSOLE_TAB_EN adds the TAB fill state.
package console_pkg;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;
`ifdef VGA_CONSOLE_TAB_EN
  typedef enum logic [2:0] {CLR_ALL, IDLE, WRITE, CLR_ROW, TAB} state_t;
`else
  typedef enum logic [2:0] {CLR_ALL, IDLE, WRITE, CLR_ROW} state_t;
`endif
  function automatic logic printable(input logic [7:0] b);
    return b >= 8'h20 && b <= 8'h7E;
  endfunction
endpackage

// File: rtl/console_fill_seq.sv
// console_fill_seq: walks len sequential addresses from start_addr, one per cycle, for blank fills.
// Ports: clk, rst (async high), start/start_addr/len load a run, active while cells remain,
// addr is the current cell, done when idle. Leaves reset already running RST_LEN cells from 0.
module console_fill_seq #(
  parameter int ADDR_W = 14,
  parameter logic [ADDR_W:0] RST_LEN = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              active,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W:0] rem;
  assign active = rem != '0;
  assign done = !active;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      rem <= RST_LEN;
    end else if (start) begin
      addr <= start_addr;
      rem <= len;
    end else if (active) begin
      addr <= addr + ADDR_W'(1);
      rem <= rem - (ADDR_W + 1)'(1);
    end
endmodule

// File: rtl/vga_console.sv
// vga_console: byte stream to text-buffer writer with cursor, wrap and row/screen clears.
// Ports: clk48, rst (async high); in_data/in_valid/in_ready byte input; vga_waddr/vga_wdata/vga_wr_en
// text-buffer write port; cur_col/cur_row cursor; busy during clears. All outputs registered.
// Macro VGA_CONSOLE_TAB_EN enables TAB expansion to the next multiple of 8 columns.
module vga_console
  import console_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int ADDR_W = 14,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic                    clk48,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDR_W-1:0]       vga_waddr,
  output logic [7:0]              vga_wdata,
  output logic                    vga_wr_en,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic                    busy
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int LW = ADDR_W + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [LW-1:0] ALL_LEN = LW'(COLS * ROWS);
  localparam logic [LW-1:0] ROW_LEN = LW'(COLS);
  state_t state;
  logic [ADDR_W-1:0] rowbase, next_base, fill_start_addr, fill_addr;
  logic [LW-1:0] fill_len;
  logic [RW-1:0] next_row;
  logic accept, advance, is_ff, is_tab, tab_adv, fill_start, fill_active, fill_done;
`ifdef VGA_CONSOLE_TAB_EN
  logic [CW:0] tab_end;
  logic tab_wrap, tab_wrap_c;
`endif
  always_comb begin
    accept = state == IDLE && in_valid && in_ready;
    next_row = cur_row == ROW_LAST ? '0 : cur_row + RW'(1);
    next_base = cur_row == ROW_LAST ? '0 : rowbase + ADDR_W'(COLS);
    is_ff = accept && in_data == CH_FF;
`ifdef VGA_CONSOLE_TAB_EN
    tab_end = {1'b0, cur_col | CW'(7)} + (CW + 1)'(1);
    tab_wrap_c = tab_end >= (CW + 1)'(COLS);
    is_tab = accept && in_data == CH_TAB;
    tab_adv = state == TAB && fill_done && tab_wrap;
`else
    is_tab = 1'b0;
    tab_adv = 1'b0;
`endif
    // a printable in the last column writes there and then advances like LF
    advance = tab_adv || (accept && (in_data == CH_LF || (printable(in_data) && cur_col == COL_LAST)));
    fill_start = advance || is_ff || is_tab;
    fill_start_addr = is_ff ? '0 : next_base;
    fill_len = is_ff ? ALL_LEN : ROW_LEN;
`ifdef VGA_CONSOLE_TAB_EN
    if (is_tab) begin
      fill_start_addr = rowbase + ADDR_W'(cur_col);
      fill_len = LW'((tab_wrap_c ? (CW + 1)'(COLS) : tab_end) - {1'b0, cur_col});
    end
`endif
  end
  console_fill_seq #(.ADDR_W(ADDR_W), .RST_LEN(ALL_LEN)) fill (
    .clk(clk48), .rst(rst), .start(fill_start), .start_addr(fill_start_addr), .len(fill_len),
    .active(fill_active), .done(fill_done), .addr(fill_addr)
  );
  always_ff @(posedge clk48 or posedge rst)
    if (rst) begin
      state <= CLR_ALL;
      in_ready <= 1'b0;
      vga_wr_en <= 1'b0;
      vga_waddr <= '0;
      vga_wdata <= BLANK;
      cur_col <= '0;
      cur_row <= '0;
      busy <= 1'b1;
      rowbase <= '0;
`ifdef VGA_CONSOLE_TAB_EN
      tab_wrap <= 1'b0;
`endif
    end else begin
      vga_wr_en <= 1'b0;
      if (advance) begin
        cur_row <= next_row;
        rowbase <= next_base;
        cur_col <= '0;
      end
      case (state)
        IDLE: if (accept) begin
          in_ready <= 1'b0;
          state <= WRITE;
          if (printable(in_data)) begin
            vga_wr_en <= 1'b1;
            vga_waddr <= rowbase + ADDR_W'(cur_col);
            vga_wdata <= in_data;
            if (cur_col != COL_LAST) cur_col <= cur_col + CW'(1);
            else begin
              state <= CLR_ROW;
              busy <= 1'b1;
            end
          end else if (in_data == CH_LF) begin
            state <= CLR_ROW;
            busy <= 1'b1;
          end else if (in_data == CH_CR) cur_col <= '0;
          else if (in_data == CH_BS && cur_col != '0) begin
            vga_wr_en <= 1'b1;
            vga_waddr <= rowbase + ADDR_W'(cur_col - CW'(1));
            vga_wdata <= BLANK;
            cur_col <= cur_col - CW'(1);
          end else if (is_ff) begin
            state <= CLR_ALL;
            busy <= 1'b1;
          end
`ifdef VGA_CONSOLE_TAB_EN
          else if (is_tab) begin
            state <= TAB;
            busy <= 1'b1;
            tab_wrap <= tab_wrap_c;
            if (!tab_wrap_c) cur_col <= tab_end[CW-1:0];
          end
`endif
        end
        WRITE: begin
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: if (fill_active) begin
          vga_wr_en <= 1'b1;
          vga_waddr <= fill_addr;
          vga_wdata <= BLANK;
        end else if (tab_adv) state <= CLR_ROW;
        else begin
          // one idle cycle after the last fill write before accepting again
          state <= IDLE;
          in_ready <= 1'b1;
          busy <= 1'b0;
          if (state == CLR_ALL) begin
            cur_col <= '0;
            cur_row <= '0;
            rowbase <= '0;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_vga_console.sv
// tb_vga_console: scoreboard bench for vga_console at 80x30; expected writes queued per byte, monitor checks.
module tb_vga_console;
  logic clk48 = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, vga_wr_en, busy;
  logic [7:0] vga_wdata;
  logic [13:0] vga_waddr;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  int total = 0, bad = 0;
  int mcol = 0, mrow = 0;
  logic [21:0] exp_q[$];

  always #5 clk48 = ~clk48;

  vga_console dut (
    .clk48(clk48), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .vga_waddr(vga_waddr), .vga_wdata(vga_wdata), .vga_wr_en(vga_wr_en),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk48)
    if (!rst && vga_wr_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected write: addr=%0d data=%h want none", vga_waddr, vga_wdata);
      end else chk("write {addr,data}", int'({vga_waddr, vga_wdata}), int'(exp_q.pop_front()));
    end

  task automatic push(input int addr, input logic [7:0] d);
    exp_q.push_back({14'(addr), d});
  endtask

  task automatic fill(input int base, input int len);
    for (int i = 0; i < len; i++) push(base + i, 8'h20);
  endtask

  task automatic adv();
    mcol = 0;
    mrow = (mrow == 29) ? 0 : mrow + 1;
    fill(mrow * 80, 80);
  endtask

  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(mrow * 80 + mcol, b);
      if (mcol == 79) adv();
      else mcol++;
    end else if (b == 8'h0A) adv();
    else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h08 && mcol > 0) begin
      mcol--;
      push(mrow * 80 + mcol, 8'h20);
    end else if (b == 8'h0C) begin
      fill(0, 2400);
      mcol = 0;
      mrow = 0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk48);
    while (!in_ready && n < 5000) begin
      @(negedge clk48);
      n++;
    end
    if (!in_ready) chk("ready timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    model(b);
    @(negedge clk48);
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 5000) begin
      @(negedge clk48);
      n++;
    end
    if (!in_ready) chk("accept timeout", 0, 1);
    @(posedge clk48);
    #1 in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " wr_en"}, vga_wr_en, 0);
    chk({tag, " waddr"}, vga_waddr, 0);
    chk({tag, " wdata"}, vga_wdata, 32);
    chk({tag, " busy"}, busy, 1);
    chk({tag, " col"}, cur_col, 0);
    chk({tag, " row"}, cur_row, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk48);
    chk_reset_vals("reset");
    fill(0, 2400);
    rst = 1'b0;
    wait_ready();
    chk("init drained", exp_q.size(), 0);
    chk("init col", cur_col, 0);
    chk("init row", cur_row, 0);
    chk("init busy", busy, 0);

    send(8'h41);
    @(negedge clk48);
    chk("A ready low", in_ready, 0);
    chk("A wr_en", vga_wr_en, 1);
    chk("A addr", vga_waddr, 0);
    @(negedge clk48);
    chk("A ready back", in_ready, 1);
    chk("A col", cur_col, 1);

    send(8'h0D);
    wait_ready();
    chk("CR col", cur_col, 0);
    for (int i = 0; i < 80; i++) send(8'h30 + 8'(i % 10));
    send(8'h42);
    wait_ready();
    chk("wrap row", cur_row, 1);
    chk("wrap col", cur_col, 1);
    chk("wrap drained", exp_q.size(), 0);

    for (int i = 0; i < 28; i++) send(8'h0A);
    wait_ready();
    chk("row 29", cur_row, 29);
    send(8'h0A);
    n = 0;
    @(negedge clk48);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk48);
    end
    chk("LF ready low cycles", n, 81);
    chk("LF wrap row", cur_row, 0);
    chk("LF wrap col", cur_col, 0);
    chk("LF drained", exp_q.size(), 0);

    send(8'h08);
    wait_ready();
    chk("BS col0 col", cur_col, 0);
    chk("BS col0 row", cur_row, 0);
    send(8'h01);
    wait_ready();
    chk("ignored col", cur_col, 0);
    chk("ignored drained", exp_q.size(), 0);

    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h78);
    send(8'h08);
    @(negedge clk48);
    chk("BS addr", vga_waddr, 164);
    chk("BS data", vga_wdata, 32);
    wait_ready();
    chk("BS col", cur_col, 4);
    chk("BS row", cur_row, 2);

    send(8'h0C);
    send(8'h5A);
    wait_ready();
    chk("held byte col", cur_col, 1);
    chk("held byte row", cur_row, 0);
    chk("held drained", exp_q.size(), 0);

    send(8'h0A);
    repeat (10) @(negedge clk48);
    chk("mid clear busy", busy, 1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 chk_reset_vals("mid reset");
    repeat (2) @(negedge clk48);
    fill(0, 2400);
    mcol = 0;
    mrow = 0;
    rst = 1'b0;
    wait_ready();
    chk("reclear drained", exp_q.size(), 0);
    chk("reclear col", cur_col, 0);
    chk("reclear row", cur_row, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
